// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decoder/ALU side and the program sequencer.
// master = sequencer view, slave = decoder/testbench view.
interface pc_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             JumpEqual;
  logic             JumpNotEqual;
  logic             OffsetEn;
  logic [1:0]       PCRegSelect;
  logic             Ack;
  logic             ZeroFlag;
  logic [OFF_W-1:0] OffsetData;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] CycleCnt;

  modport master (
    input  Start, StartAddr, JumpEqual, JumpNotEqual, OffsetEn,
           PCRegSelect, Ack, ZeroFlag, OffsetData,
    output ProgCtr, Running, Done, CycleCnt
  );

  modport slave (
    output Start, StartAddr, JumpEqual, JumpNotEqual, OffsetEn,
           PCRegSelect, Ack, ZeroFlag, OffsetData,
    input  ProgCtr, Running, Done, CycleCnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: program counter, three saved-jump registers, run/halt
// handshake and saturating run-cycle counter for the 9-bit core.
module pc_sequencer #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.master bus
);

  localparam int unsigned NREG = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pcreg_q [NREG];
  logic [PC_W-1:0]  pcreg_d [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, done_q;

  logic             jump_c;
  logic             taken_c;
  logic             sel_nz_c;
  logic [1:0]       sel_idx_c;
  logic [PC_W-1:0]  pc_inc_c;
  logic [PC_W-1:0]  offset_c;

  // Both jump flags high resolves to taken, as the OR of the two terms covers every ZeroFlag.
  assign jump_c    = bus.JumpEqual | bus.JumpNotEqual;
  assign taken_c   = (bus.JumpEqual & bus.ZeroFlag) | (bus.JumpNotEqual & ~bus.ZeroFlag);
  assign sel_nz_c  = (bus.PCRegSelect != 2'd0);
  assign sel_idx_c = 2'(bus.PCRegSelect - 2'd1);
  assign pc_inc_c  = pc_q + PC_W'(1);
  assign offset_c  = bus.OffsetEn ? PC_W'(bus.OffsetData) : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) pcreg_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_HALT);
      for (int i = 0; i < int'(NREG); i++) pcreg_q[i] <= pcreg_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(NREG); i++) pcreg_d[i] = pcreg_q[i];

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          pc_d    = bus.StartAddr;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (bus.Ack) begin
          state_d = S_HALT;
        end else if (jump_c) begin
          pc_d = (taken_c && sel_nz_c) ? pcreg_q[sel_idx_c] : pc_inc_c;
        end else if (sel_nz_c) begin
          pcreg_d[sel_idx_c] = pc_q + offset_c;
          pc_d               = pc_inc_c;
        end else begin
          pc_d = pc_inc_c;
        end
      end
      S_HALT: begin
        // A new run needs Start to drop first, so leaving HALT only on Start low.
        if (!bus.Start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ProgCtr  = pc_q;
  assign bus.Running  = running_q;
  assign bus.Done     = done_q;
  assign bus.CycleCnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  // Reference model: mode 0=idle 1=run 2=halt, plain integers for everything else.
  int m_mode;
  int m_pc;
  int m_cnt;
  int m_reg [3];

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < 3; i++) m_reg[i] = 0;
  endtask

  task automatic model_step();
    int  sel;
    int  off;
    bit  je, jne, z;
    sel = int'(bus.PCRegSelect);
    je  = bus.JumpEqual;
    jne = bus.JumpNotEqual;
    z   = bus.ZeroFlag;
    off = bus.OffsetEn ? int'(bus.OffsetData) : 0;
    case (m_mode)
      0: if (bus.Start) begin
        m_pc   = int'(bus.StartAddr);
        m_cnt  = 0;
        m_mode = 1;
      end
      1: begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (bus.Ack) m_mode = 2;
        else if (je || jne) begin
          if (((je && z) || (jne && !z)) && sel != 0) m_pc = m_reg[sel-1];
          else m_pc = (m_pc + 1) % 1024;
        end else begin
          if (sel != 0) m_reg[sel-1] = (m_pc + off) % 1024;
          m_pc = (m_pc + 1) % 1024;
        end
      end
      default: if (!bus.Start) m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    check("prog_ctr",  32'(bus.ProgCtr),  32'(m_pc));
    check("running",   32'(bus.Running),  32'(m_mode == 1));
    check("done",      32'(bus.Done),     32'(m_mode == 2));
    check("cycle_cnt", 32'(bus.CycleCnt), 32'(m_cnt));
  endtask

  task automatic step();
    model_step();
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  task automatic idle_ctrl();
    bus.JumpEqual    = 1'b0;
    bus.JumpNotEqual = 1'b0;
    bus.OffsetEn     = 1'b0;
    bus.PCRegSelect  = 2'd0;
    bus.Ack          = 1'b0;
    bus.ZeroFlag     = 1'b0;
    bus.OffsetData   = '0;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    Reset = 1'b0;
  endtask

  task automatic start_at(input logic [9:0] addr);
    bus.Start     = 1'b1;
    bus.StartAddr = addr;
    step();
    check("start_pc", 32'(bus.ProgCtr), 32'(addr));
    bus.Start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    bus.Start     = 1'b0;
    bus.StartAddr = '0;
    idle_ctrl();
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    compare_all();
    Reset = 1'b0;

    // Plain run from 0x010 for five cycles.
    start_at(10'h010);
    repeat (5) step();
    check("run5_pc",  32'(bus.ProgCtr),  32'h015);
    check("run5_cnt", 32'(bus.CycleCnt), 32'd5);
    check("run5_run", 32'(bus.Running),  32'd1);

    // Save PCreg2 with offset, jump back through it, then an untaken jne.
    apply_reset();
    start_at(10'h020);
    bus.PCRegSelect = 2'd2; bus.OffsetEn = 1'b1; bus.OffsetData = 8'h07;
    step();
    idle_ctrl();
    step();
    bus.JumpEqual = 1'b1; bus.ZeroFlag = 1'b1; bus.PCRegSelect = 2'd2;
    step();
    check("je_taken_pc", 32'(bus.ProgCtr), 32'h027);
    bus.JumpEqual = 1'b0; bus.JumpNotEqual = 1'b1;
    step();
    check("jne_untaken_pc", 32'(bus.ProgCtr), 32'h028);

    // Ack wins over a taken jump; Start held keeps HALT, Start low returns to IDLE.
    idle_ctrl();
    bus.Ack = 1'b1; bus.JumpEqual = 1'b1; bus.ZeroFlag = 1'b1; bus.PCRegSelect = 2'd2;
    bus.Start = 1'b1;
    step();
    check("halt_pc",   32'(bus.ProgCtr), 32'h028);
    check("halt_done", 32'(bus.Done),    32'd1);
    idle_ctrl();
    repeat (3) step();
    check("halt_hold", 32'(bus.Done), 32'd1);
    bus.Start = 1'b0;
    step();
    check("idle_done", 32'(bus.Done), 32'd0);

    // Program counter wrap and cycle counter saturation.
    start_at(10'h3FF);
    step();
    check("wrap_pc", 32'(bus.ProgCtr), 32'h000);
    repeat (65540) step();
    check("sat_cnt", 32'(bus.CycleCnt), 32'hFFFF);

    // Asynchronous reset between edges, released with Start already high.
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check("arst_pc",  32'(bus.ProgCtr),  32'h0);
    check("arst_run", 32'(bus.Running),  32'h0);
    check("arst_cnt", 32'(bus.CycleCnt), 32'h0);
    bus.Start = 1'b1;
    bus.StartAddr = 10'h155;
    #1;
    Reset = 1'b0;
    step();
    check("arst_start_pc",  32'(bus.ProgCtr), 32'h155);
    check("arst_start_run", 32'(bus.Running), 32'h1);

    // Randomized control traffic.
    for (int k = 0; k < 2000; k++) begin
      bus.Start        = ($urandom_range(0, 3) != 0);
      bus.StartAddr    = 10'($urandom);
      bus.JumpEqual    = ($urandom_range(0, 3) == 0);
      bus.JumpNotEqual = ($urandom_range(0, 3) == 0);
      bus.OffsetEn     = 1'($urandom);
      bus.PCRegSelect  = 2'($urandom);
      bus.Ack          = ($urandom_range(0, 29) == 0);
      bus.ZeroFlag     = 1'($urandom);
      bus.OffsetData   = 8'($urandom);
      if ($urandom_range(0, 4) == 0) bus.Start = 1'b0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
